regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the pipelined MIPS core. It replaces the fixed 2-read/1-write register file in the decode stage. It provides NR registered read ports and NW write ports with deterministic write priority and same-cycle write-to-read bypass. It also holds the architectural HI/LO pair and exposes the syscall registers (v0, a0) continuously.

## Interface
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of general registers; power of two, ≥ 2; AW = $clog2(DEPTH).
- NR, 2: number of read ports, 1..8.
- NW, 2: number of write ports, 1..4; port NW-1 has the highest priority.
- SP_IDX, 29: index of the stack pointer.
- SP_INIT, 32'h7FFF_FFFC: reset value of the stack pointer.
- V0_IDX, 2 / A0_IDX, 4: indices driven onto v0/a0.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NR*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NR*DATA_W  registered read data; port i uses bits [i*DATA_W +: DATA_W].
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*AW  write addresses.
- wr_data  in  NW*DATA_W  write data.
- hilo_we  in  1  load HI and LO this cycle.
- hi_in, lo_in  in  DATA_W  HI/LO write data.
- hi_out, lo_out  out  DATA_W  current HI/LO (registered).
- v0, a0  out  DATA_W  current contents of regs[V0_IDX] and regs[A0_IDX].

## Operation
- Register 0 is hardwired zero:
  - writes to address 0 are discarded;
  - reads of address 0 return 0, including during bypass.
- Write resolution per target address:
  - among enabled ports with a nonzero address, the highest-numbered port wins;
  - lower-priority writes to the same address are dropped with no error.
- Read port i, each posedge:
  - rd_data[i] ← the value regs[rd_addr[i]] will hold after this edge's writes (write-first bypass);
  - the winning wr_data for a matching address is forwarded, otherwise the stored value.
- Reads have no enable; every port samples every cycle.
- HI/LO: when hilo_we is set, hi_out/lo_out take hi_in/lo_in at posedge; otherwise they hold.
- v0/a0 are combinational from storage and reflect writes one posedge after they are issued. They are not bypassed.
- Arithmetic: none. Data is stored unmodified and truncated to DATA_W.

## Timing
- Write latency: 1 cycle. Data is visible in storage, v0/a0 and hi_out/lo_out after the posedge where wr_en/hilo_we was sampled.
- Read latency: 1 cycle, address to rd_data. A same-cycle write to the same address returns the new data.
- Reset (rst sampled high at posedge):
  - all registers ← 0, except regs[SP_IDX] ← SP_INIT;
  - hi_out, lo_out, every rd_data ← 0;
  - v0, a0 = 0 afterwards (unless V0_IDX or A0_IDX equals SP_IDX).
- rst overrides every write and read in the same cycle. Reset asserted mid-stream discards in-flight writes.
- First cycle after reset deassertion: normal reads/writes. Reads return the reset values unless bypassed.
- Simultaneous events:
  - all NW writes to distinct addresses commit in the same cycle;
  - hilo_we is independent of the GPR ports;
  - a read of SP_IDX in the cycle rst is high returns 0 on rd_data. Storage holds SP_INIT.

## Structure
- Shared package regfile_pkg holds:
  - AW derivation;
  - architectural index constants: ZERO=0, V0=2, A0=4, SP=29, RA=31;
  - SP_INIT default.
  The core include header re-uses these constants in place of its local defines.
- One sub-module, regfile_wr_arb. It is combinational per-address priority resolution: inputs are wr_en/wr_addr/wr_data; outputs are per-register hit and data. It is shared by the storage update and the bypass path so both apply identical priority.
- Storage is a DEPTH×DATA_W array; the read path is generate-looped over NR.

## Test plan
- Reset: drive rst=1 one cycle, then read addresses 29 and 5 -> rd_data = 32'h7FFF_FFFC and 0; hi_out = lo_out = 0.
- Write then read: write 32'hDEAD_BEEF to reg 8 on port 0; next cycle read 8 on both ports -> both return 32'hDEAD_BEEF one cycle later.
- Bypass: in one cycle write 32'h1234 to reg 3 and read reg 3 -> rd_data = 32'h1234 on the following edge, not the old value.
- Priority/zero:
  - port 0 writes 32'hAAAA and port 1 writes 32'hBBBB to reg 7 -> reg 7 = 32'hBBBB;
  - any write to reg 0 -> reads of reg 0 stay 0.
- HI/LO + v0/a0: hilo_we with hi_in=5, lo_in=9 -> hi_out=5, lo_out=9 next cycle; write reg 2 = 10 -> v0 = 10 after one posedge.
- Reset mid-operation: assert rst in the same cycle as a write of 32'hFFFF to reg 4 -> a0 = 0 and reg 4 reads 0 afterward.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared address-width helper, architectural register indices and stack-pointer reset value
package regfile_pkg;
  localparam int REG_ZERO = 0;
  localparam int REG_V0 = 2;
  localparam int REG_A0 = 4;
  localparam int REG_SP = 29;
  localparam int REG_RA = 31;
  localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_FFFC;
  function automatic int aw_of(input int depth);
    return depth < 2 ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: per-register write priority (highest enabled port wins, reg 0 never hit); in wr_en_i/wr_addr_i/wr_data_i, out hit_o/data_o
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int NW = 2
) (
  input  logic [NW-1:0]                  wr_en_i,
  input  logic [NW*aw_of(DEPTH)-1:0]     wr_addr_i,
  input  logic [NW*DATA_W-1:0]           wr_data_i,
  output logic [DEPTH-1:0]               hit_o,
  output logic [DEPTH-1:0][DATA_W-1:0]   data_o
);
  localparam int AW = aw_of(DEPTH);
  always_comb begin
    hit_o = '0;
    data_o = '0;
    for (int r = 1; r < DEPTH; r++) begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == AW'(r)) begin
          hit_o[r] = 1'b1;
          data_o[r] = wr_data_i[p*DATA_W +: DATA_W];
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR-read/NW-write register file with write-first bypass, HI/LO pair and v0/a0 taps; in clk/rst/rd_addr/wr_en/wr_addr/wr_data/hilo_we/hi_in/lo_in, out rd_data/hi_out/lo_out/v0/a0
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int NR = 2,
  parameter int NW = 2,
  parameter int SP_IDX = REG_SP,
  parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEF,
  parameter int V0_IDX = REG_V0,
  parameter int A0_IDX = REG_A0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NR*aw_of(DEPTH)-1:0] rd_addr,
  output logic [NR*DATA_W-1:0]       rd_data,
  input  logic [NW-1:0]              wr_en,
  input  logic [NW*aw_of(DEPTH)-1:0] wr_addr,
  input  logic [NW*DATA_W-1:0]       wr_data,
  input  logic                       hilo_we,
  input  logic [DATA_W-1:0]          hi_in,
  input  logic [DATA_W-1:0]          lo_in,
  output logic [DATA_W-1:0]          hi_out,
  output logic [DATA_W-1:0]          lo_out,
  output logic [DATA_W-1:0]          v0,
  output logic [DATA_W-1:0]          a0
);
  localparam int AW = aw_of(DEPTH);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0][DATA_W-1:0] wdata;
  logic [DATA_W-1:0] hi_q, lo_q;
  regfile_wr_arb #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NW(NW)) u_arb (
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .hit_o    (hit),
    .data_o   (wdata)
  );
  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (rst) regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
      else if (hit[r]) regs_q[r] <= wdata[r];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DATA_W-1:0] rd_q, rd_d;
    assign a = rd_addr[i*AW +: AW];
    assign rd_d = hit[a] ? wdata[a] : regs_q[a];
    always_ff @(posedge clk) rd_q <= rst ? '0 : rd_d;
    assign rd_data[i*DATA_W +: DATA_W] = rd_q;
  end
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign v0 = regs_q[V0_IDX];
  assign a0 = regs_q[A0_IDX];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus randomized traffic checked against an array model of regfile_mp
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [63:0] wr_data;
  logic hilo_we;
  logic [31:0] hi_in, lo_in, hi_out, lo_out, v0, a0;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out), .v0(v0), .a0(a0)
  );
  typedef struct {
    logic rst;
    logic [1:0] we;
    logic [4:0] wa0;
    logic [31:0] wd0;
    logic [4:0] wa1;
    logic [31:0] wd1;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic hw;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic [31:0] ev0;
    logic [31:0] ea0;
  } vec_t;
  vec_t vec [13];
  logic [31:0] m [32];
  logic [31:0] mhi, mlo, mrd0, mrd1;
  int total = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    wr_en = v.we;
    wr_addr = {v.wa1, v.wa0};
    wr_data = {v.wd1, v.wd0};
    rd_addr = {v.ra1, v.ra0};
    hilo_we = v.hw;
    hi_in = v.hi;
    lo_in = v.lo;
    @(posedge clk);
    if (v.rst) begin
      foreach (m[r]) m[r] = '0;
      m[29] = 32'h7FFF_FFFC;
      mhi = '0;
      mlo = '0;
      mrd0 = '0;
      mrd1 = '0;
    end else begin
      if (v.we[0] && v.wa0 != 0) m[v.wa0] = v.wd0;
      if (v.we[1] && v.wa1 != 0) m[v.wa1] = v.wd1;
      if (v.hw) begin
        mhi = v.hi;
        mlo = v.lo;
      end
      mrd0 = m[v.ra0];
      mrd1 = m[v.ra1];
    end
    #1;
  endtask
  function automatic logic [4:0] pick_addr();
    logic [4:0] hot [5];
    hot = '{5'd0, 5'd2, 5'd4, 5'd7, 5'd29};
    return ($urandom_range(0, 1) == 0) ? hot[$urandom_range(0, 4)] : 5'($urandom_range(0, 31));
  endfunction
  initial begin
    vec_t v;
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    hilo_we = 1'b0; hi_in = '0; lo_in = '0;
    vec[0]  = '{1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[1]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b0, 32'h0, 32'h0,
                32'h7FFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[2]  = '{1'b0, 2'b01, 5'd8, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[3]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b0, 32'h0, 32'h0,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[4]  = '{1'b0, 2'b01, 5'd3, 32'h1234, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 32'h0, 32'h0,
                32'h1234, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[5]  = '{1'b0, 2'b11, 5'd7, 32'hAAAA, 5'd7, 32'hBBBB, 5'd7, 5'd7, 1'b0, 32'h0, 32'h0,
                32'hBBBB, 32'hBBBB, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[6]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd3, 1'b0, 32'h0, 32'h0,
                32'hBBBB, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[7]  = '{1'b0, 2'b11, 5'd0, 32'hFFFF, 5'd0, 32'hEEEE, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[8]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b0, 32'h0, 32'h0,
                32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[9]  = '{1'b0, 2'b01, 5'd2, 32'd10, 5'd0, 32'h0, 5'd2, 5'd4, 1'b1, 32'd5, 32'd9,
                32'd10, 32'h0, 32'd5, 32'd9, 32'd10, 32'h0};
    vec[10] = '{1'b1, 2'b01, 5'd4, 32'hFFFF, 5'd0, 32'h0, 5'd4, 5'd29, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[11] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd29, 1'b0, 32'h0, 32'h0,
                32'h0, 32'h7FFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0};
    vec[12] = '{1'b0, 2'b11, 5'd4, 32'd44, 5'd2, 32'd22, 5'd2, 5'd4, 1'b0, 32'd7, 32'd8,
                32'd22, 32'd44, 32'h0, 32'h0, 32'd22, 32'd44};
    foreach (vec[k]) begin
      step(vec[k]);
      chk($sformatf("vec%0d rd0", k), rd_data[31:0], vec[k].e0);
      chk($sformatf("vec%0d rd1", k), rd_data[63:32], vec[k].e1);
      chk($sformatf("vec%0d hi", k), hi_out, vec[k].ehi);
      chk($sformatf("vec%0d lo", k), lo_out, vec[k].elo);
      chk($sformatf("vec%0d v0", k), v0, vec[k].ev0);
      chk($sformatf("vec%0d a0", k), a0, vec[k].ea0);
    end
    for (int n = 0; n < 500; n++) begin
      v.rst = ($urandom_range(0, 39) == 0);
      v.we = 2'($urandom_range(0, 3));
      v.wa0 = pick_addr();
      v.wa1 = ($urandom_range(0, 3) == 0) ? v.wa0 : pick_addr();
      v.wd0 = $urandom;
      v.wd1 = $urandom;
      v.ra0 = ($urandom_range(0, 2) == 0) ? v.wa1 : pick_addr();
      v.ra1 = ($urandom_range(0, 2) == 0) ? v.wa0 : pick_addr();
      v.hw = 1'($urandom_range(0, 1));
      v.hi = $urandom;
      v.lo = $urandom;
      step(v);
      chk($sformatf("rnd%0d rd0", n), rd_data[31:0], mrd0);
      chk($sformatf("rnd%0d rd1", n), rd_data[63:32], mrd1);
      chk($sformatf("rnd%0d hi", n), hi_out, mhi);
      chk($sformatf("rnd%0d lo", n), lo_out, mlo);
      chk($sformatf("rnd%0d v0", n), v0, m[2]);
      chk($sformatf("rnd%0d a0", n), a0, m[4]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
